// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam int DATA_BITS = 8;
  localparam int DEFAULT_TRANS_INTERVAL = 10000;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer of uart_rx to rx_s; rx_vote is the 3-sample majority when UART_RX_MAJORITY_EN is defined, else rx_s
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic uart_rx,
  output logic rx_s,
  output logic rx_vote
);
  logic meta;
  always_ff @(posedge clk)
    if (reset) {rx_s, meta} <= 2'b11;
    else {rx_s, meta} <= {meta, uart_rx};
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  always_ff @(posedge clk) hist <= reset ? 2'b11 : {hist[0], rx_s};
  assign rx_vote = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign rx_vote = rx_s;
`endif
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver (clk, reset, uart_rx in; data/valid/ack handshake, frame_err pulse, sticky overrun, busy); UART_RX_MAJORITY_EN enables majority sampling
module uart_receiver
  import uart_pkg::*;
#(
  parameter int TRANS_INTERVAL = DEFAULT_TRANS_INTERVAL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int HALF = TRANS_INTERVAL / 2;
  state_t state, state_nxt;
  logic [31:0] clock_count, cc_nxt, lim;
  logic [2:0] bit_count, bc_nxt;
  logic [7:0] shift, shift_nxt;
  logic rx_s, rx_vote, expire, deliver, ferr_nxt;
  uart_rx_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .uart_rx(uart_rx),
    .rx_s   (rx_s),
    .rx_vote(rx_vote)
  );
  assign lim = state == START ? 32'(HALF) : 32'(TRANS_INTERVAL);
  assign expire = clock_count + 32'd1 >= lim;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    cc_nxt = clock_count;
    bc_nxt = bit_count;
    shift_nxt = shift;
    deliver = 1'b0;
    ferr_nxt = 1'b0;
    case (state)
      IDLE:
        if (!rx_s) begin
          state_nxt = START;
          cc_nxt = '0;
        end
      START:
        if (!expire) cc_nxt = clock_count + 32'd1;
        else begin
          cc_nxt = '0;
          bc_nxt = '0;
          state_nxt = rx_vote ? IDLE : DATA;
        end
      DATA:
        if (!expire) cc_nxt = clock_count + 32'd1;
        else begin
          cc_nxt = '0;
          shift_nxt[bit_count] = rx_vote;
          bc_nxt = bit_count + 3'd1;
          state_nxt = bit_count == 3'(DATA_BITS - 1) ? STOP : DATA;
        end
      STOP:
        if (!expire) cc_nxt = clock_count + 32'd1;
        else begin
          cc_nxt = '0;
          deliver = rx_vote;
          ferr_nxt = !rx_vote;
          state_nxt = rx_vote ? IDLE : BREAK;
        end
      BREAK: state_nxt = rx_s ? IDLE : BREAK;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      clock_count <= '0;
      bit_count <= '0;
      shift <= '0;
      frame_err <= 1'b0;
      data <= '0;
      valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      clock_count <= cc_nxt;
      bit_count <= bc_nxt;
      shift <= shift_nxt;
      frame_err <= ferr_nxt;
      if (deliver) begin
        if (!valid || ack) data <= shift;
        if (valid && !ack) overrun <= 1'b1;
        valid <= 1'b1;
      end else if (ack && valid) begin
        valid <= 1'b0;
        overrun <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized and directed frames checked against a frame-level scoreboard
module tb_uart_receiver;
  localparam int T = 16;
  localparam int STOP_IT = 154;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GLITCH_EXP = 8'h0F;
`else
  localparam logic [7:0] GLITCH_EXP = 8'h0B;
`endif
  if (T < 4) begin : g_bad_interval
    $error("TRANS_INTERVAL must be at least 4");
  end
  logic clk = 1'b0, reset = 1'b1, uart_rx = 1'b1, ack = 1'b0;
  logic [7:0] data;
  logic valid, frame_err, overrun, busy;
  int checks = 0, failures = 0;
  int it, rise_at, ferr_cnt, ferr_at;
  logic prev_valid, busy_end;
  logic [7:0] md = 8'h00;
  logic mv = 1'b0, mo = 1'b0;
  always #5 clk = ~clk;
  uart_receiver #(.TRANS_INTERVAL(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .data     (data),
    .valid    (valid),
    .ack      (ack),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clear_mon();
    it = 0;
    rise_at = -1;
    ferr_cnt = 0;
    ferr_at = -1;
    prev_valid = valid;
  endtask
  task automatic step(input logic lvl, input logic a, input logic r);
    uart_rx = lvl;
    ack = a;
    reset = r;
    @(posedge clk);
    #1;
    if (valid && !prev_valid && rise_at < 0) rise_at = it;
    if (frame_err) begin
      ferr_cnt++;
      if (ferr_at < 0) ferr_at = it;
    end
    prev_valid = valid;
    it++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int tail, input int ack_it,
                      input int glitch_it, input int rst_it);
    logic lvl;
    clear_mon();
    for (int c = 0; c < 160 + tail; c++) begin
      lvl = c < 16 ? 1'b0 : c < 144 ? b[(c - 16) / 16] : c < 160 ? stop : 1'b0;
      if (c == glitch_it) lvl = ~lvl;
      step(lvl, c == ack_it, c == rst_it);
      if (c == rst_it) begin
        check("rst_valid", int'(valid), 0);
        check("rst_data", int'(data), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_ovr", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);
      end
      if (c == 159) busy_end = busy;
    end
    uart_rx = 1'b1;
    ack = 1'b0;
    reset = 1'b0;
  endtask
  task automatic model_ack();
    if (mv) begin
      mv = 1'b0;
      mo = 1'b0;
    end
  endtask
  task automatic model_deliver(input logic [7:0] b, input logic ack_now);
    if (!mv) begin
      md = b;
      mv = 1'b1;
    end else if (ack_now) md = b;
    else mo = 1'b1;
  endtask
  task automatic check_state(input string tag);
    check({tag, "_data"}, int'(data), int'(md));
    check({tag, "_valid"}, int'(valid), int'(mv));
    check({tag, "_ovr"}, int'(overrun), int'(mo));
  endtask
  task automatic ack_now(input string tag);
    step(1'b1, 1'b1, 1'b0);
    model_ack();
    check_state(tag);
  endtask
  // ack_mode: 0 none, 1 ack in the delivery cycle, 2 ack early in the frame
  task automatic frame(input string tag, input logic [7:0] b, input logic [7:0] b_exp, input logic stop,
                       input int ack_mode, input int gapn, input int glitch_it);
    logic pre;
    if (ack_mode == 2) model_ack();
    pre = mv;
    if (stop) model_deliver(b_exp, ack_mode == 1);
    else if (ack_mode == 1) model_ack();
    send(b, stop, 0, ack_mode == 1 ? STOP_IT : ack_mode == 2 ? 40 : -1, glitch_it, -1);
    check({tag, "_rise"}, rise_at, (stop && !pre) ? STOP_IT : -1);
    check({tag, "_ferrn"}, ferr_cnt, stop ? 0 : 1);
    if (!stop) check({tag, "_ferrat"}, ferr_at, STOP_IT);
    check({tag, "_busy"}, int'(busy_end), stop ? 0 : 1);
    idle(stop ? gapn : (gapn < 3 ? 3 : gapn));
    check_state(tag);
  endtask
  initial begin
    logic [7:0] rb;
    logic rs;
    int am;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", int'(valid), 0);
    check("reset_data", int'(data), 0);
    check("reset_ferr", int'(frame_err), 0);
    check("reset_ovr", int'(overrun), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    idle(4);
    frame("a5", 8'hA5, 8'hA5, 1'b1, 0, 2, -1);
    ack_now("a5_ack");
    send(8'h3C, 1'b0, 40, -1, -1, -1);
    check("brk_ferrn", ferr_cnt, 1);
    check("brk_valid", int'(valid), 0);
    check("brk_busy_low", int'(busy), 1);
    idle(3);
    check("brk_busy_high", int'(busy), 0);
    frame("b2b_11", 8'h11, 8'h11, 1'b1, 0, 0, -1);
    frame("b2b_22", 8'h22, 8'h22, 1'b1, 0, 2, -1);
    ack_now("b2b_ack");
    clear_mon();
    repeat (3) step(1'b0, 1'b0, 1'b0);
    idle(20);
    check("glitch_rise", rise_at, -1);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_busy", int'(busy), 0);
    check("glitch_valid", int'(valid), 0);
    frame("pre_55", 8'h55, 8'h55, 1'b1, 0, 2, -1);
    frame("ackdel_22", 8'h22, 8'h22, 1'b1, 1, 2, -1);
    send(8'hFF, 1'b1, 0, -1, -1, 85);
    md = 8'h00;
    mv = 1'b0;
    mo = 1'b0;
    idle(3);
    check_state("post_rst");
    frame("rx_81", 8'h81, 8'h81, 1'b1, 0, 2, -1);
    frame("maj_0f", 8'h0F, GLITCH_EXP, 1'b1, 2, 2, 8 + 3 * T);
    for (int n = 0; n < 16; n++) begin
      rb = 8'($urandom_range(0, 255));
      rs = $urandom_range(0, 3) != 0;
      am = $urandom_range(0, 2);
      frame("rnd", rb, rb, rs, am, $urandom_range(0, 3), -1);
    end
    ack_now("final_ack");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
